cache_miss_controller: RTL and testbench

CACHE_MISS_CONTROLLER -- requirements
Module: cache_miss_controller

---
 rtl/cache_miss_controller.sv | 156 +++++++++++++++
 tb/tb_cache_miss_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_controller.sv
// Miss controller for a direct-mapped, write-through, no-write-allocate cache.
// Optional hit/miss statistics outputs are enabled with the CACHE_STATS_EN macro.
module cache_miss_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  hit_i,
    input  logic [DATA_WIDTH-1:0] cache_data_i,
    output logic                  cache_fill_o,
    output logic [DATA_WIDTH-1:0] cache_addr_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        FILL   = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   fill_data_q;

    logic idle_req;
    logic store_hit_now;

    generate
        if (SET_WIDTH < 1 || SET_WIDTH > DATA_WIDTH) begin : g_bad_set_width
            $error("SET_WIDTH must lie between 1 and DATA_WIDTH");
        end
    endgenerate

    assign idle_req      = (state == IDLE) && req_valid_i;
    assign store_hit_now = idle_req && req_write_i && hit_i;

    // Latched request drives the memory bus directly, so it stays stable until ack.
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // Combinational outputs are gated by rst_n so every output reads 0 during reset.
    always_comb begin
        stall_o       = 1'b0;
        cache_fill_o  = 1'b0;
        cache_addr_o  = '0;
        cache_wdata_o = '0;
        if (rst_n) begin
            stall_o = (state != IDLE) ||
                      (req_valid_i && (req_write_i || !hit_i));
            if (state == FILL) begin
                cache_fill_o  = 1'b1;
                cache_addr_o  = addr_q;
                cache_wdata_o = fill_data_q;
            end else if (store_hit_now) begin
                cache_fill_o  = 1'b1;
                cache_addr_o  = addr_i;
                cache_wdata_o = wdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            fill_data_q <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            rdata_o     <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (req_write_i) begin
                            addr_q    <= addr_i;
                            wdata_q   <= wdata_i;
                            mem_req_o <= 1'b1;
                            mem_we_o  <= 1'b1;
                            state     <= MEM_WR;
                        end else if (hit_i) begin
                            rdata_o <= cache_data_i;
                            done_o  <= 1'b1;
                        end else begin
                            addr_q    <= addr_i;
                            mem_req_o <= 1'b1;
                            mem_we_o  <= 1'b0;
                            state     <= MEM_RD;
                        end
                    end
                end
                MEM_RD: begin
                    if (mem_ack_i) begin
                        fill_data_q <= mem_rdata_i;
                        mem_req_o   <= 1'b0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    rdata_o <= fill_data_q;
                    done_o  <= 1'b1;
                    state   <= IDLE;
                end
                MEM_WR: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Counted at request acceptance; counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (idle_req && !req_write_i) begin
            if (hit_i) begin
                hit_count_o <= hit_count_o + 32'd1;
            end else begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Randomized transaction-level bench for cache_miss_controller; each access type
// has its expected cycle-by-cycle behaviour written out directly.
module tb_cache_miss_controller;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i, req_write_i, hit_i, mem_ack_i;
    logic [DW-1:0] addr_i, wdata_i, cache_data_i, mem_rdata_i;
    logic          cache_fill_o, mem_req_o, mem_we_o, stall_o, done_o;
    logic [DW-1:0] cache_addr_o, cache_wdata_o, mem_addr_o, mem_wdata_o, rdata_o;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_count_o, miss_count_o;
`endif

    int            n_vec  = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_rdata;
    int unsigned   exp_hits, exp_misses;

    always #5 clk = ~clk;

    cache_miss_controller #(.DATA_WIDTH(DW), .SET_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .hit_i(hit_i), .cache_data_i(cache_data_i),
        .cache_fill_o(cache_fill_o), .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .done_o(done_o)
`ifdef CACHE_STATS_EN
        , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats();
`ifdef CACHE_STATS_EN
        chk("hit_count", hit_count_o, 64'(exp_hits));
        chk("miss_count", miss_count_o, 64'(exp_misses));
`endif
    endtask

    task automatic noise();
        req_valid_i  = 1'($urandom);
        req_write_i  = 1'($urandom);
        hit_i        = 1'($urandom);
        addr_i       = $urandom;
        wdata_i      = $urandom;
        cache_data_i = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, stall_o, 0);
        chk({tag, ".fill"}, cache_fill_o, 0);
        chk({tag, ".caddr"}, cache_addr_o, 0);
        chk({tag, ".cwdata"}, cache_wdata_o, 0);
        chk({tag, ".mem_req"}, mem_req_o, 0);
        chk({tag, ".mem_we"}, mem_we_o, 0);
        chk({tag, ".mem_addr"}, mem_addr_o, 0);
        chk({tag, ".mem_wdata"}, mem_wdata_o, 0);
        chk({tag, ".rdata"}, rdata_o, 0);
        chk({tag, ".done"}, done_o, 0);
    endtask

    task automatic do_idle(input logic ack);
        noise();
        req_valid_i = 1'b0;
        mem_ack_i   = ack;
        @(negedge clk);
        chk("idle.stall", stall_o, 0);
        chk("idle.fill", cache_fill_o, 0);
        chk("idle.mem_req", mem_req_o, 0);
        tick();
        chk("idle.done", done_o, 0);
        chk("idle.rdata", rdata_o, exp_rdata);
    endtask

    task automatic do_load_hit(input logic [DW-1:0] a, input logic [DW-1:0] d);
        req_valid_i = 1'b1; req_write_i = 1'b0; hit_i = 1'b1;
        addr_i = a; cache_data_i = d; wdata_i = $urandom;
        mem_ack_i = 1'($urandom);
        @(negedge clk);
        chk("lh.stall", stall_o, 0);
        chk("lh.fill", cache_fill_o, 0);
        tick();
        exp_rdata = d;
        exp_hits++;
        chk("lh.done", done_o, 1);
        chk("lh.rdata", rdata_o, exp_rdata);
        chk("lh.mem_req", mem_req_o, 0);
        chk_stats();
    endtask

    task automatic do_load_miss(input logic [DW-1:0] a, input logic [DW-1:0] r, input int n);
        req_valid_i = 1'b1; req_write_i = 1'b0; hit_i = 1'b0;
        addr_i = a; cache_data_i = $urandom; wdata_i = $urandom;
        mem_ack_i = 1'($urandom);
        @(negedge clk);
        chk("lm.req_stall", stall_o, 1);
        chk("lm.req_fill", cache_fill_o, 0);
        tick();
        exp_misses++;
        for (int k = 1; k <= n; k++) begin
            noise();
            mem_ack_i   = (k == n);
            mem_rdata_i = (k == n) ? r : $urandom;
            @(negedge clk);
            chk("lm.stall", stall_o, 1);
            chk("lm.mem_req", mem_req_o, 1);
            chk("lm.mem_we", mem_we_o, 0);
            chk("lm.mem_addr", mem_addr_o, a);
            chk("lm.fill", cache_fill_o, 0);
            chk("lm.done", done_o, 0);
            tick();
        end
        noise();
        mem_ack_i   = 1'($urandom);
        mem_rdata_i = $urandom;
        @(negedge clk);
        chk("lm.fill_strobe", cache_fill_o, 1);
        chk("lm.fill_addr", cache_addr_o, a);
        chk("lm.fill_data", cache_wdata_o, r);
        chk("lm.fill_stall", stall_o, 1);
        chk("lm.fill_mem_req", mem_req_o, 0);
        chk("lm.fill_done", done_o, 0);
        tick();
        exp_rdata = r;
        chk("lm.done", done_o, 1);
        chk("lm.rdata", rdata_o, exp_rdata);
        chk_stats();
    endtask

    task automatic do_store(input logic [DW-1:0] a, input logic [DW-1:0] w,
                            input logic h, input int n);
        req_valid_i = 1'b1; req_write_i = 1'b1; hit_i = h;
        addr_i = a; wdata_i = w; cache_data_i = $urandom;
        mem_ack_i = 1'($urandom);
        @(negedge clk);
        chk("st.stall", stall_o, 1);
        chk("st.fill", cache_fill_o, h);
        if (h) begin
            chk("st.fill_addr", cache_addr_o, a);
            chk("st.fill_data", cache_wdata_o, w);
        end
        tick();
        for (int k = 1; k <= n; k++) begin
            noise();
            mem_ack_i = (k == n);
            @(negedge clk);
            chk("st.stall_busy", stall_o, 1);
            chk("st.mem_req", mem_req_o, 1);
            chk("st.mem_we", mem_we_o, 1);
            chk("st.mem_addr", mem_addr_o, a);
            chk("st.mem_wdata", mem_wdata_o, w);
            chk("st.fill_busy", cache_fill_o, 0);
            chk("st.done_busy", done_o, 0);
            tick();
        end
        chk("st.done", done_o, 1);
        chk("st.mem_req_after", mem_req_o, 0);
        chk("st.rdata_held", rdata_o, exp_rdata);
        chk_stats();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_i = 1'b0; req_write_i = 1'b0; hit_i = 1'b0; mem_ack_i = 1'b0;
        addr_i = '0; wdata_i = '0; cache_data_i = '0; mem_rdata_i = '0;
        exp_rdata = '0; exp_hits = 0; exp_misses = 0;
        #1;
        chk_all_zero("reset");
        chk_stats();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Spurious ack in idle, then back-to-back hit and miss.
        do_idle(1'b1);
        do_load_hit(32'h0000_0040, 32'hCAFE_0001);
        do_load_miss(32'h0000_0044, 32'h0BAD_F00D, 2);

        do_load_hit(32'h0000_0010, 32'hDEAD_BEEF);
        do_load_miss(32'h0000_0010, 32'h1234_5678, 3);
        do_store(32'h0000_0020, 32'hA5A5_A5A5, 1'b1, 2);
        do_store(32'h0000_0024, 32'h5A5A_5A5A, 1'b0, 1);
        do_idle(1'b0);

        // Reset two cycles into a read miss.
        req_valid_i = 1'b1; req_write_i = 1'b0; hit_i = 1'b0;
        addr_i = 32'h0000_0010; mem_ack_i = 1'b0;
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        req_valid_i = 1'b1; req_write_i = 1'b1; hit_i = 1'b1;
        addr_i = 32'h0000_0080; wdata_i = 32'h1111_2222;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_8888;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        exp_rdata = '0; exp_hits = 0; exp_misses = 0;
        repeat (2) tick();
        chk_all_zero("rst_hold");
        chk_stats();
        rst_n = 1'b1;
        do_load_hit(32'h0000_0030, 32'h0F0F_0F0F);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: do_idle(1'($urandom));
                1: do_load_hit($urandom, $urandom);
                2: do_load_miss($urandom, $urandom, int'($urandom_range(1, 4)));
                3: do_store($urandom, $urandom, 1'b1, int'($urandom_range(1, 4)));
                default: do_store($urandom, $urandom, 1'b0, int'($urandom_range(1, 4)));
            endcase
        end
        do_idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
